// File: rtl/seq_divider_8bit_if.sv
// Start/done handshake bundle for the sequential divider.
//   master: drives start, dividend, divisor; observes the result side.
//   slave:  the divider; observes the request side, drives busy, done,
//           quotient, remainder, div_by_zero.
interface seq_divider_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per cycle.
// The trial subtraction A + ~M + 1 runs on 4-bit carry-lookahead slices.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of seq_divider_8bit_if:
//            start/dividend/divisor in; busy, done (1-cycle pulse),
//            quotient, remainder, div_by_zero out (all registered)
// Latency WIDTH+1 cycles from accepted start to done; divide-by-zero
// answers in one cycle with quotient all-ones and remainder = dividend.
module seq_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    seq_divider_8bit_if.slave bus
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned CW     = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    // The restoring step always leaves A < M, so the top bit of the
    // WIDTH+1-bit partial remainder is zero between cycles and is not stored.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Trial subtraction datapath: add_a - {0,M} over WIDTH+1 bits.
    logic [WIDTH:0]   add_a, add_b;
    logic [WIDTH-1:0] trial;
    logic [NSLICE:0]  slice_c;
    logic             carry;

    assign add_a      = {a_q, q_q[WIDTH-1]};
    assign add_b      = ~{1'b0, m_q};
    assign slice_c[0] = 1'b1;

    for (genvar s = 0; s < NSLICE; s++) begin : g_cla
        logic [3:0] g, p;
        logic [4:0] c;
        assign g    = add_a[4*s +: 4] & add_b[4*s +: 4];
        assign p    = add_a[4*s +: 4] ^ add_b[4*s +: 4];
        assign c[0] = slice_c[s];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
        assign trial[4*s +: 4] = p ^ c[3:0];
        assign slice_c[s+1]    = c[4];
    end

    // Top bit is a plain full adder; only its carry-out (no borrow) is needed.
    assign carry = (add_a[WIDTH] & add_b[WIDTH])
                 | ((add_a[WIDTH] ^ add_b[WIDTH]) & slice_c[NSLICE]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        a_d     = '0;
                        q_d     = bus.dividend;
                        m_d     = bus.divisor;
                        count_d = CW'(WIDTH);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                a_d     = carry ? trial : add_a[WIDTH-1:0];
                q_d     = {q_q[WIDTH-2:0], carry};
                count_d = count_q - CW'(1);
                if (count_d == '0) begin
                    quot_d  = q_d;
                    rem_d   = a_d;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit against an arithmetic reference.
module tb_seq_divider_8bit;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    // Expected contents of the result registers (last completed operation).
    logic [7:0] eq, er;
    logic       ez;

    seq_divider_8bit_if #(.WIDTH(8)) bus ();

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned division, all-ones/dividend on zero divisor.
    task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic z);
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Issue one start and wait for done (sampled at negedges).
    // lat: negedges after the accepting edge until done (-1 on timeout).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cycles, output int hold_bad);
        lat = -1; busy_cycles = 0; hold_bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez)
                hold_bad++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; bus.dividend = 8'd0; bus.divisor = 8'd0;
        #2;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_in: outputs=%h required 0",
                {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        #21 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_after: outputs=%h required 0",
                {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        eq = 8'd0; er = 8'd0; ez = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc, hb;
        do_op(8'd100, 8'd7, lat, bc, hb);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d required 8", lat); end
        checks++;
        if (bc !== 9) begin errors++; $display("FAIL basic_busy: got %0d required 9", bc); end
        checks++;
        if (hb !== 0) begin errors++; $display("FAIL basic_hold: %0d bad cycles required 0", hb); end
        checks++;
        if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got %0d/%0d z=%b required 14/2 z=0",
                bus.quotient, bus.remainder, bus.div_by_zero);
        end
        eq = 8'd14; er = 8'd2; ez = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] rq, rr;
        logic       rz;
        int lat, bc, hb;
        ta = '{8'd255, 8'd5, 8'd255};
        tb = '{8'd1, 8'd9, 8'd255};
        for (int i = 0; i < 3; i++) begin
            ref_div(ta[i], tb[i], rq, rr, rz);
            do_op(ta[i], tb[i], lat, bc, hb);
            checks++;
            if (lat !== 8 || hb !== 0) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: lat=%0d hold_bad=%0d required 8 0", i, lat, hb);
            end
            checks++;
            if (bus.quotient !== rq || bus.remainder !== rr || bus.div_by_zero !== rz) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got %0d/%0d z=%b required %0d/%0d z=%b",
                    i, bus.quotient, bus.remainder, bus.div_by_zero, rq, rr, rz);
            end
            eq = rq; er = rr; ez = rz;
        end
    endtask

    task automatic test_div_zero;
        int lat, bc, hb;
        do_op(8'd37, 8'd0, lat, bc, hb);
        checks++;
        if (lat !== 0 || bc !== 1) begin
            errors++;
            $display("FAIL dz_timing: lat=%0d busy=%0d required 0 1", lat, bc);
        end
        checks++;
        if (bus.quotient !== 8'd255 || bus.remainder !== 8'd37 || bus.div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got %0d/%0d z=%b required 255/37 z=1",
                bus.quotient, bus.remainder, bus.div_by_zero);
        end
        eq = 8'd255; er = 8'd37; ez = 1'b1;
        do_op(8'd12, 8'd4, lat, bc, hb);
        checks++;
        if (lat !== 8 || hb !== 0) begin
            errors++;
            $display("FAIL dz_follow_timing: lat=%0d hold_bad=%0d required 8 0", lat, hb);
        end
        checks++;
        if (bus.quotient !== 8'd3 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_follow_result: got %0d/%0d z=%b required 3/0 z=0",
                bus.quotient, bus.remainder, bus.div_by_zero);
        end
        eq = 8'd3; er = 8'd0; ez = 1'b0;
    endtask

    task automatic test_start_held;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) begin bus.dividend = 8'd17; bus.divisor = 8'd5; end
            if (bus.done) begin lat = k; break; end
        end
        checks++;
        if (lat !== 8 || bus.quotient !== 8'd66 || bus.remainder !== 8'd2) begin
            errors++;
            $display("FAIL held_result: lat=%0d got %0d/%0d required 8 66/2",
                lat, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: busy=%b required 0", bus.busy);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL held_reaccept: busy=%b required 1", bus.busy);
        end
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = k; break; end
        end
        checks++;
        if (lat !== 8 || bus.quotient !== 8'd3 || bus.remainder !== 8'd2) begin
            errors++;
            $display("FAIL held_second: lat=%0d got %0d/%0d required 8 3/2",
                lat, bus.quotient, bus.remainder);
        end
        eq = 8'd3; er = 8'd2; ez = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, hb, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd250; bus.divisor = 8'd6;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_clear: outputs=%h required 0",
                {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        #2 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: %0d active cycles required 0", seen);
        end
        eq = 8'd0; er = 8'd0; ez = 1'b0;
        do_op(8'd250, 8'd6, lat, bc, hb);
        checks++;
        if (lat !== 8 || hb !== 0 || bus.quotient !== 8'd41 || bus.remainder !== 8'd4) begin
            errors++;
            $display("FAIL midreset_retry: lat=%0d hold_bad=%0d got %0d/%0d required 8 0 41/4",
                lat, hb, bus.quotient, bus.remainder);
        end
        eq = 8'd41; er = 8'd4; ez = 1'b0;
    endtask

    task automatic test_random_sweep;
        logic [7:0] a, b, rq, rr;
        logic       rz;
        int lat, bc, hb, bad;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(255, 1));
            if (i == 0) begin a = 8'd0; b = 8'd1; end
            if (i == 1) begin a = 8'd254; b = 8'd255; end
            ref_div(a, b, rq, rr, rz);
            do_op(a, b, lat, bc, hb);
            bad = 0;
            if (lat !== 8 || hb !== 0) bad++;
            if (bus.quotient !== rq || bus.remainder !== rr || bus.div_by_zero !== rz) bad++;
            if (16'(bus.quotient) * 16'(b) + 16'(bus.remainder) !== 16'(a)) bad++;
            if (bus.remainder >= b) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL sweep %0d/%0d: got %0d/%0d z=%b lat=%0d required %0d/%0d z=%b lat=8",
                    a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, rq, rr, rz);
            end
            eq = rq; er = rr; ez = rz;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_held();
        test_reset_mid_run();
        test_random_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
